// File: rtl/bcd_countdown_core.sv
// bcd_countdown_core: NDIG-digit BCD countdown with field setting, pause, done alarm and LED animation.
// Optional auto-reload from DONE is enabled by defining CDT_AUTO_RELOAD_EN.
module bcd_countdown_core #(
  parameter int NDIG        = 4,
  parameter int TOP_MAX     = 23,
  parameter int LED_W       = 16,
  parameter int ALARM_TICKS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                btn_sel,
  input  logic                btn_inc,
  input  logic                btn_start,
  input  logic                btn_pause,
  output logic [4*NDIG-1:0]   digits,
  output logic [1:0]          state,
  output logic [2:0]          field,
  output logic                alarm,
  output logic [LED_W-1:0]    led
);
  localparam int NF = NDIG / 2;
  localparam int DW = $clog2(ALARM_TICKS + 1);
  typedef enum logic [1:0] {SET = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  state_t              state_q, state_d;
  logic [4*NDIG-1:0]   set_val_q, set_val_d, cnt_q, cnt_d, inc_val, dec_val;
  logic [2:0]          field_q, field_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic [3:0]          lo, hi;
  logic [7:0]          fv;
  logic                wrap, brw;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SET;
      set_val_q <= '0;
      cnt_q     <= '0;
      field_q   <= '0;
      led_q     <= '0;
      dcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      set_val_q <= set_val_d;
      cnt_q     <= cnt_d;
      field_q   <= field_d;
      led_q     <= led_d;
      dcnt_q    <= dcnt_d;
    end
  end
  // Increment the selected field; the top field wraps at TOP_MAX, the others at 59.
  always_comb begin
    inc_val = set_val_q;
    lo      = 4'd0;
    hi      = 4'd0;
    fv      = 8'd0;
    wrap    = 1'b0;
    for (int f = 0; f < NF; f++) begin
      if (f == int'(field_q)) begin
        lo   = set_val_q[8*f +: 4];
        hi   = set_val_q[8*f+4 +: 4];
        fv   = 8'(hi) * 8'd10 + 8'(lo);
        wrap = (f == NF - 1) ? (fv == 8'(TOP_MAX)) : (hi == 4'd5 && lo == 4'd9);
        inc_val[8*f +: 8] = wrap ? 8'h00 : (lo == 4'd9) ? {hi + 4'd1, 4'd0} : {hi, lo + 4'd1};
      end
    end
  end
  // Borrow ripples up from digit 0; base-60 tens digits reload to 5.
  always_comb begin
    dec_val = cnt_q;
    brw     = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (brw) begin
        if (cnt_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = (i % 2 == 0 || i == NDIG - 1) ? 4'd9 : 4'd5;
        end else begin
          dec_val[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
          brw = 1'b0;
        end
      end
    end
  end
  always_comb begin
    state_d   = state_q;
    set_val_d = set_val_q;
    cnt_d     = cnt_q;
    field_d   = field_q;
    led_d     = led_q;
    dcnt_d    = dcnt_q;
    case (state_q)
      SET: begin
        if (btn_start) begin
          if (set_val_q != '0) begin
            cnt_d   = set_val_q;
            state_d = RUN;
            led_d   = LED_W'(1);
          end
        end else begin
          set_val_d = btn_inc ? inc_val : set_val_q;
          field_d   = !btn_sel ? field_q : (field_q == 3'(NF - 1)) ? 3'd0 : field_q + 3'd1;
        end
      end
      RUN: begin
        if (btn_start) begin
          state_d = SET;
          led_d   = '0;
        end else if (btn_pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          cnt_d = dec_val;
          led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
          if (dec_val == '0) begin
            state_d = DONE;
            led_d   = '1;
            dcnt_d  = '0;
          end
        end
      end
      PAUSE: begin
        if (btn_start) begin
          state_d = SET;
          led_d   = '0;
        end else if (btn_pause) begin
          state_d = RUN;
        end
      end
      default: begin
        if (btn_start) begin
          state_d = SET;
          led_d   = '0;
        end else if (!btn_pause && tick) begin
          led_d  = ~led_q;
`ifdef CDT_AUTO_RELOAD_EN
          dcnt_d = dcnt_q + DW'(1);
          if (dcnt_q == DW'(ALARM_TICKS - 1)) begin
            cnt_d   = set_val_q;
            state_d = RUN;
            led_d   = LED_W'(1);
          end
`else
          dcnt_d = (dcnt_q == DW'(ALARM_TICKS)) ? dcnt_q : dcnt_q + DW'(1);
`endif
        end
      end
    endcase
  end
  assign digits = (state_q == SET) ? set_val_q : cnt_q;
  assign state  = state_q;
  assign field  = field_q;
  assign alarm  = (state_q == DONE);
  assign led    = led_q;
endmodule
